// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader: legal segment patterns,
// the blank pattern and the acceptance FSM state encoding.
// Segment bit order is bit0=a .. bit6=g, active high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DIGIT = 2'd1,
    BLANK = 2'd2,
    BAD   = 2'd3
  } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Purpose: classify a 7-bit segment pattern as digit / blank / bad.
// Latency: combinational, zero cycles.
// Backpressure: none, pure lookup.
// Ports: pat (segment pattern in), is_digit, is_blank, digit_val (0..9, 0 when not a digit).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] digit_val
);

  always_comb begin
    is_digit  = 1'b1;
    is_blank  = 1'b0;
    digit_val = 4'd0;
    case (pat)
      SEG_0:     digit_val = 4'd0;
      SEG_1:     digit_val = 4'd1;
      SEG_2:     digit_val = 4'd2;
      SEG_3:     digit_val = 4'd3;
      SEG_4:     digit_val = 4'd4;
      SEG_5:     digit_val = 4'd5;
      SEG_6:     digit_val = 4'd6;
      SEG_7:     digit_val = 4'd7;
      SEG_8:     digit_val = 4'd8;
      SEG_9:     digit_val = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Purpose: debounce a seven-segment pattern, decode it, time digit changes, flag broken counting.
// Latency: accepted on the STABLE_CYCLES-th consecutive identical sample; outputs registered at that edge.
// Backpressure: none; seg_in is sampled every cycle, shorter glitches are silently discarded.
// Ports: clk, rst (async, active high), seg_in[6:0]; outputs digit, digit_valid, blank,
//        bad_pattern, changed (1-cycle pulse), interval[CNT_W-1:0], step_err (sticky).
module seven_segment_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             bad_pattern,
  output logic             changed,
  output logic [CNT_W-1:0] interval,
  output logic             step_err
);

  localparam logic [3:0] CNT_MAX    = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ACCEPT = 4'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

  seg7_state_t      state;
  logic [6:0]       cand;
  logic [3:0]       cnt;
  logic [6:0]       acc_pat;   // pattern currently accepted; meaningless in NONE
  logic [CNT_W-1:0] gap;
  logic             seen_chg;  // first change since reset leaves interval at 0

  logic       dec_is_digit;
  logic       dec_is_blank;
  logic [3:0] dec_digit;

  seg7_pattern_decode u_decode (
    .pat       (seg_in),
    .is_digit  (dec_is_digit),
    .is_blank  (dec_is_blank),
    .digit_val (dec_digit)
  );

  logic       accept;
  logic       new_accept;
  logic       new_digit;
  logic [3:0] next_digit;

  // Acceptance fires exactly once per stable run because cnt saturates past it.
  assign accept     = (seg_in == cand) && (cnt == CNT_ACCEPT);
  // Re-accepting the pattern already shown (e.g. after a short glitch) is a no-op.
  assign new_accept = accept && !((state != NONE) && (seg_in == acc_pat));
  assign new_digit  = new_accept && dec_is_digit;
  assign next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NONE;
      cand        <= 7'd0;
      cnt         <= 4'd0;
      acc_pat     <= 7'd0;
      gap         <= '0;
      seen_chg    <= 1'b0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      bad_pattern <= 1'b0;
      changed     <= 1'b0;
      interval    <= '0;
      step_err    <= 1'b0;
    end else begin
      changed <= 1'b0;

      if (seg_in != cand) begin
        cand <= seg_in;
        cnt  <= 4'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 4'd1;
      end

      if (new_digit)
        gap <= '0;
      else if (gap != SAT)
        gap <= gap + 1'b1;

      if (new_accept) begin
        acc_pat <= seg_in;
        if (dec_is_digit) begin
          state       <= DIGIT;
          digit       <= dec_digit;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          bad_pattern <= 1'b0;
          changed     <= 1'b1;
          seen_chg    <= 1'b1;
          if (seen_chg)
            interval <= (gap == SAT) ? SAT : gap + 1'b1;
          // Only a direct digit-to-digit step is judged; passing through blank/bad resets the chain.
          if (state == DIGIT && dec_digit != next_digit)
            step_err <= 1'b1;
        end else if (dec_is_blank) begin
          state       <= BLANK;
          digit_valid <= 1'b0;
          blank       <= 1'b1;
          bad_pattern <= 1'b0;
        end else begin
          state       <= BAD;
          digit_valid <= 1'b0;
          blank       <= 1'b0;
          bad_pattern <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with STABLE_CYCLES=4, CNT_W=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seven_segment_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        blank;
  logic        bad_pattern;
  logic        changed;
  logic [15:0] interval;
  logic        step_err;

  int total = 0;
  int bad   = 0;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segment_reader #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .bad_pattern (bad_pattern),
    .changed     (changed),
    .interval    (interval),
    .step_err    (step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".digit"},    32'(digit), 32'd0);
    chk({tag, ".valid"},    32'(digit_valid), 32'd0);
    chk({tag, ".blank"},    32'(blank), 32'd0);
    chk({tag, ".bad"},      32'(bad_pattern), 32'd0);
    chk({tag, ".changed"},  32'(changed), 32'd0);
    chk({tag, ".interval"}, 32'(interval), 32'd0);
    chk({tag, ".step_err"}, 32'(step_err), 32'd0);
  endtask

  initial begin
    int pulses;
    rst    = 1'b1;
    seg_in = 7'h00;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Digit 0 accepted on the 4th edge, first change leaves interval 0.
    seg_in = 7'h3F;
    tick(); tick(); tick();
    chk("t1.early_valid", 32'(digit_valid), 32'd0);
    tick();
    chk("t1.digit", 32'(digit), 32'd0);
    chk("t1.valid", 32'(digit_valid), 32'd1);
    chk("t1.changed", 32'(changed), 32'd1);
    chk("t1.interval", 32'(interval), 32'd0);
    tick();
    chk("t1.changed_drop", 32'(changed), 32'd0);

    // 1 held too briefly, then 2: skip from 0 to 2 flags step_err.
    seg_in = 7'h06;
    tick(); tick(); tick();
    seg_in = 7'h5B;
    tick(); tick(); tick();
    chk("t2.no_one", 32'(digit), 32'd0);
    chk("t2.no_pulse", 32'(changed), 32'd0);
    tick();
    chk("t2.digit", 32'(digit), 32'd2);
    chk("t2.changed", 32'(changed), 32'd1);
    chk("t2.step_err", 32'(step_err), 32'd1);
    chk("t2.interval", 32'(interval), 32'd8);

    // Clean count 0..9,0 at 10 edges per digit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int d = 0; d < 11; d++) begin
      seg_in = pats[d % 10];
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (changed) pulses++;
        if (k == 4) begin
          chk($sformatf("t3.changed%0d", d), 32'(changed), 32'd1);
          chk($sformatf("t3.digit%0d", d), 32'(digit), 32'(d % 10));
          chk($sformatf("t3.interval%0d", d), 32'(interval), (d == 0) ? 32'd0 : 32'd10);
        end
      end
    end
    chk("t3.pulses", 32'(pulses), 32'd11);
    chk("t3.step_err", 32'(step_err), 32'd0);

    // Bad pattern then blank; digit register holds.
    seg_in = 7'h7A;
    tick(); tick(); tick();
    chk("t4.bad_early", 32'(bad_pattern), 32'd0);
    tick();
    chk("t4.bad", 32'(bad_pattern), 32'd1);
    chk("t4.valid", 32'(digit_valid), 32'd0);
    chk("t4.digit", 32'(digit), 32'd0);
    chk("t4.changed", 32'(changed), 32'd0);
    seg_in = 7'h00;
    tick(); tick(); tick(); tick();
    chk("t4.blank", 32'(blank), 32'd1);
    chk("t4.bad_clr", 32'(bad_pattern), 32'd0);
    chk("t4.valid2", 32'(digit_valid), 32'd0);
    chk("t4.step_err", 32'(step_err), 32'd0);

    // Blank -> 0, then glitch and re-accept of the same 0: no second pulse.
    seg_in = 7'h3F;
    tick(); tick(); tick(); tick();
    chk("t5.changed", 32'(changed), 32'd1);
    chk("t5.step_err", 32'(step_err), 32'd0);
    seg_in = 7'h06;
    tick(); tick();
    seg_in = 7'h3F;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (changed) pulses++;
    end
    chk("t5.same_pat_pulses", 32'(pulses), 32'd0);
    chk("t5.digit", 32'(digit), 32'd0);

    // 3 accepted, 4 in flight when reset hits; full run needed afterwards.
    seg_in = 7'h4F;
    tick(); tick(); tick(); tick();
    chk("t6.digit3", 32'(digit), 32'd3);
    seg_in = 7'h66;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk_all_zero("t6.in_reset");
    tick();
    chk_all_zero("t6.in_reset2");
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6.early_valid", 32'(digit_valid), 32'd0);
    tick();
    chk("t6.digit4", 32'(digit), 32'd4);
    chk("t6.valid", 32'(digit_valid), 32'd1);
    chk("t6.changed", 32'(changed), 32'd1);
    chk("t6.step_err", 32'(step_err), 32'd0);
    chk("t6.interval", 32'(interval), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
